hsi_tx_arbiter: RTL
===================

Name: hsi_tx_arbiter

Overview:
- Shares the single HSI message coder between up to N_REQ message sources (control-command-word, status, data controllers).
- Each source raises a request and receives an exclusive grant, which it uses as its transmit-ready.
- While granted, the source's byte stream is forwarded to the coder. Release happens on the source's message end.
- Round-robin fairness, an enforced inter-message gap and drop detection complete the block.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- GAP_CYC, 2, idle cycles between end of one message and next grant (0..15).
- TIMEOUT, 255, max cycles in GRANT without an accepted byte (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-source transmit request, level.
- gnt  out  N_REQ  one-hot grant; drives the source's tx_rdy.
- src_d  in  8*N_REQ  source byte; source i occupies bits [8i+7:8i].
- src_d_rdy  in  N_REQ  one-cycle byte strobe per source.
- src_msg_end  in  N_REQ  one-cycle end-of-message per source.
- cd_busy  in  1  coder busy serialising a byte.
- cd_d  out  8  byte to coder.
- cd_wr  out  1  one-cycle write strobe to coder.
- owner  out  max(1,ceil(log2 N_REQ))  index of current/last owner.
- busy  out  1  high in any state except IDLE.
- drop_err  out  1  sticky: byte strobed while coder busy.
- tmo  out  1  one-cycle timeout pulse.

Behaviour:
Clock and reset:
- Single clock; reset is synchronous and active-high on rst.
- Reset values: gnt=0, cd_d=0, cd_wr=0, owner=0, busy=0, drop_err=0, tmo=0, state=IDLE.
- Round-robin pointer resets so source 0 has highest priority.
- rst mid-message aborts immediately; no drain is performed.

States: IDLE, GRANT, DRAIN, GAP.

IDLE:
- If req != 0, pick the first set bit, searching cyclically from owner+1. After reset the search starts at bit 0.
- owner is loaded, gnt[owner] is registered high and the state moves to GRANT.
- Latency req to gnt is 1 cycle.

GRANT:
- gnt = one-hot(owner). Only the owner's inputs are observed; other sources' src_d_rdy and src_msg_end are ignored.
- Byte forwarding:
  - src_d_rdy[owner] with cd_busy=0: next cycle cd_d = src_d[owner] and cd_wr = 1 for exactly one cycle.
  - src_d_rdy[owner] with cd_busy=1: byte dropped, no cd_wr, and drop_err is set. drop_err stays set until rst.
- Release:
  - Triggered by src_msg_end[owner], or by req[owner] going low.
  - gnt goes to 0 the next cycle and the state moves to DRAIN.
  - A byte strobed in the same cycle as src_msg_end is still forwarded.

DRAIN:
- Wait until cd_busy=0 and cd_wr=0.
- Then go to GAP with gap counter = GAP_CYC, or directly to IDLE if GAP_CYC=0.

GAP:
- Decrement the counter each cycle; go to IDLE when it reaches 0. gnt stays 0 and requests are ignored.

Other rules:
- A requester that keeps req high is re-granted only after all other pending requesters have been served.
- cd_d holds its last value when cd_wr=0.
- The gap counter is 4-bit. The timeout counter is 8-bit and saturating.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, a counter clears on grant entry and on every forwarded byte, and increments otherwise.
  - When it reaches TIMEOUT: tmo pulses for 1 cycle, gnt drops next cycle and the state moves to DRAIN (forced release).
  - The owner pointer advances as on a normal release.
- Not defined: no counter is synthesised, tmo is tied 0, and GRANT ends only on src_msg_end or req withdrawal.

Test Plan:
1. req=3'b010 only, cd_busy low between bytes; source 1 strobes A5,01,00,3C then msg_end → gnt=3'b010 one cycle after req; four cd_wr pulses with cd_d=A5,01,00,3C each 1 cycle after strobe; gnt=0 after msg_end; busy low 2 cycles after DRAIN exit.
2. req=3'b111 held after reset, each source sends 1 byte + msg_end → grant order 0,1,2,0; owner=0,1,2,0; gnt never multi-hot; ≥2 idle cycles between grants.
3. Owner strobes 0x55 while cd_busy=1 → no cd_wr, drop_err=1 and stays 1 through later messages until rst.
4. rst asserted one cycle after a cd_wr during GRANT → next cycle gnt=0, cd_wr=0, busy=0, drop_err=0, owner=0; then req=3'b100 → gnt=3'b100 after 1 cycle.
5. Owner deasserts req mid-message without msg_end → gnt=0 next cycle, DRAIN then GAP, next pending requester granted.
6. ARB_TIMEOUT_EN, TIMEOUT=8, source 0 granted but never strobes → tmo pulse 8 cycles after GRANT entry, gnt=0 next cycle. Without the macro: gnt held indefinitely and tmo=0.

Source files
------------

// File: rtl/hsi_tx_arbiter.sv
// Round-robin arbiter sharing one HSI message coder between N_REQ sources.
// Define ARB_TIMEOUT_EN to force release of a grant that stalls for TIMEOUT cycles.
module hsi_tx_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned OwW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     gnt,
  input  logic [8*N_REQ-1:0]   src_d,
  input  logic [N_REQ-1:0]     src_d_rdy,
  input  logic [N_REQ-1:0]     src_msg_end,
  input  logic                 cd_busy,
  output logic [7:0]           cd_d,
  output logic                 cd_wr,
  output logic [OwW-1:0]       owner,
  output logic                 busy,
  output logic                 drop_err,
  output logic                 tmo
);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain, StGap} state_e;

  state_e             state_q, state_d;
  logic [OwW-1:0]     owner_q, owner_d;
  logic [OwW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]         cd_d_q, cd_d_d;
  logic               cd_wr_q, cd_wr_d;
  logic               drop_err_q, drop_err_d;
  logic [3:0]         gap_q, gap_d;

  logic [7:0]         src_b [N_REQ];
  logic               pick_vld;
  logic [OwW-1:0]     pick_idx;
  logic [OwW-1:0]     idx;
  logic               own_rdy, own_end, own_req, fwd;
  logic               tmo_hit;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      src_b[i] = src_d[8*i +: 8];
    end
  end

  // Cyclic search from ptr_q; descending loop so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = OwW'((int'(ptr_q) + k) % N_REQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign own_rdy = src_d_rdy[owner_q];
  assign own_end = src_msg_end[owner_q];
  assign own_req = req[owner_q];
  assign fwd     = (state_q == StGrant) && own_rdy && !cd_busy;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLim = 8'(TIMEOUT);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StIdle) begin
      tmo_cnt_d = '0;
    end else if (state_q == StGrant) begin
      if (fwd) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q != 8'hff) begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit = (state_q == StGrant) && (tmo_cnt_q == TmoLim);
  assign tmo     = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cd_d_d     = cd_d_q;
    cd_wr_d    = 1'b0;
    drop_err_d = drop_err_q;
    gap_d      = gap_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          owner_d         = pick_idx;
          ptr_d           = OwW'((int'(pick_idx) + 1) % N_REQ);
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          state_d         = StGrant;
        end
      end
      StGrant: begin
        if (own_rdy) begin
          if (cd_busy) begin
            drop_err_d = 1'b1;
          end else begin
            cd_wr_d = 1'b1;
            cd_d_d  = src_b[owner_q];
          end
        end
        if (own_end || !own_req || tmo_hit) begin
          gnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!cd_busy && !cd_wr_q) begin
          if (GAP_CYC == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = 4'(GAP_CYC);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cd_d_q     <= '0;
      cd_wr_q    <= 1'b0;
      drop_err_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cd_d_q     <= cd_d_d;
      cd_wr_q    <= cd_wr_d;
      drop_err_q <= drop_err_d;
      gap_q      <= gap_d;
    end
  end

  assign gnt      = gnt_q;
  assign cd_d     = cd_d_q;
  assign cd_wr    = cd_wr_q;
  assign owner    = owner_q;
  assign busy     = (state_q != StIdle);
  assign drop_err = drop_err_q;

endmodule
